bp_fpga_host_io_responder: RTL and testbench

// - BedRock IO-memory responder on the BP side of bp_fpga_host: consumes io_cmd issued by the host, returns io_resp.
// - Emulates the device window the host targets:
//   - putchar sink
//   - finish register
//   - small dword scratch RAM
// - Replaces the test loopback and is the on-board target for NBF loads and host I/O bring-up.

---
 rtl/bp_fpga_host_pkg.sv | 126 ++++++++++++
 rtl/bp_io_responder_scratch_ram.sv | 38 +++
 rtl/bp_fpga_host_io_responder.sv | 193 +++++++++++++++++++
 tb/tb_bp_fpga_host_io_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fpga_host_pkg.sv
// bp_fpga_host_pkg
//   Shared types and constants for the BP-side host IO responder:
//   BedRock IO message layout, device-window addresses, responder FSM states,
//   decoded-target enum and small decode/byte-lane helper functions.
//   Optional feature macro: BP_IO_RESPONDER_PERF_EN (maps the PERF counter).
package bp_fpga_host_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg = 2'd0
   } bp_params_e;

   localparam int paddr_width_gp = 40;

   // Physical address width for a processor configuration
   function automatic int bp_paddr_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 40;
         default:          return 40;
      endcase
   endfunction

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [paddr_width_gp-1:0] addr;
      bp_bedrock_msg_size_e      size;
      bp_bedrock_mem_type_e      msg_type;
   } bp_bedrock_io_mem_header_s;

   typedef struct packed {
      logic [63:0]               data;
      bp_bedrock_io_mem_header_s header;
   } bp_bedrock_io_mem_msg_s;

   // Device window; the scratch span (8 B * depth) must stay below PERF
   localparam logic [paddr_width_gp-1:0] io_putchar_addr_gp  = 40'h00_0010_1000;
   localparam logic [paddr_width_gp-1:0] io_finish_addr_gp   = 40'h00_0010_2000;
   localparam logic [paddr_width_gp-1:0] io_scratch_base_gp  = 40'h00_0010_3000;
   localparam logic [paddr_width_gp-1:0] io_perf_addr_gp     = 40'h00_0010_4000;

   typedef enum logic [1:0] {
      e_ready  = 2'd0,
      e_access = 2'd1,
      e_resp   = 2'd2
   } bp_io_resp_state_e;

   typedef enum logic [2:0] {
      e_tgt_none    = 3'd0,
      e_tgt_putchar = 3'd1,
      e_tgt_finish  = 3'd2,
      e_tgt_scratch = 3'd3,
      e_tgt_perf    = 3'd4
   } bp_io_target_e;

   // Low address bits that must be zero for an access of this size
   function automatic logic [2:0] bp_io_size_mask_f(input bp_bedrock_msg_size_e size);
      case (size)
         e_bedrock_msg_size_1: return 3'b000;
         e_bedrock_msg_size_2: return 3'b001;
         e_bedrock_msg_size_4: return 3'b011;
         default:              return 3'b111;
      endcase
   endfunction

   // Byte-lane write mask for a size at a byte offset within the dword
   function automatic logic [7:0] bp_io_byte_mask_f(input bp_bedrock_msg_size_e size,
                                                    input logic [2:0] off);
      logic [7:0] m;
      case (size)
         e_bedrock_msg_size_1: m = 8'h01;
         e_bedrock_msg_size_2: m = 8'h03;
         e_bedrock_msg_size_4: m = 8'h0F;
         e_bedrock_msg_size_8: m = 8'hFF;
         default:              m = 8'h00;
      endcase
      return m << off;
   endfunction

   // Map a command onto a device target; bad type, size or alignment -> none
   function automatic bp_io_target_e bp_io_decode_f(input logic [paddr_width_gp-1:0] addr,
                                                    input bp_bedrock_msg_size_e size,
                                                    input bp_bedrock_mem_type_e msg_type,
                                                    input int lg_els);
      logic type_ok;
      logic aligned;
      bp_io_target_e tgt;
      type_ok = (msg_type == e_bedrock_mem_uc_rd) || (msg_type == e_bedrock_mem_uc_wr);
      aligned = (size <= e_bedrock_msg_size_8)
             && ((addr[2:0] & bp_io_size_mask_f(size)) == 3'b000);
      if (!type_ok || !aligned)
         tgt = e_tgt_none;
      else if (addr == io_putchar_addr_gp)
         tgt = e_tgt_putchar;
      else if (addr == io_finish_addr_gp)
         tgt = e_tgt_finish;
`ifdef BP_IO_RESPONDER_PERF_EN
      else if (addr == io_perf_addr_gp)
         tgt = e_tgt_perf;
`endif
      // Full-address compare of everything above the dword index
      else if ((addr >> (3 + lg_els)) == (io_scratch_base_gp >> (3 + lg_els)))
         tgt = e_tgt_scratch;
      else
         tgt = e_tgt_none;
      return tgt;
   endfunction

endpackage

// File: rtl/bp_io_responder_scratch_ram.sv
// bp_io_responder_scratch_ram
//   Single-port synchronous scratch RAM, els_p x 64 bits, byte-masked writes,
//   registered read data. Contents are not reset.
//   Ports: clk_i, v_i (access), w_i (write), addr_i (dword index),
//          data_i / mask_i (write data and byte enables), data_o (read data).
module bp_io_responder_scratch_ram
#(
   parameter  int els_p     = 64,
   localparam int addr_w_lp = $clog2(els_p)
)
(
   input  logic                 clk_i,
   input  logic                 v_i,
   input  logic                 w_i,
   input  logic [addr_w_lp-1:0] addr_i,
   input  logic [63:0]          data_i,
   input  logic [7:0]           mask_i,
   output logic [63:0]          data_o
);

   logic [63:0] mem_q [els_p];
   logic [63:0] data_q;

   // Byte-masked write or registered read; read data holds between reads
   always_ff @(posedge clk_i) begin
      if (v_i && w_i) begin
         for (int b = 0; b < 8; b++) begin
            if (mask_i[b])
               mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
         end
      end else if (v_i) begin
         data_q <= mem_q[addr_i];
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/bp_fpga_host_io_responder.sv
// bp_fpga_host_io_responder
//   BedRock IO-memory responder on the BP side of bp_fpga_host. Accepts one
//   io_cmd at a time and returns an io_resp two cycles later, emulating a
//   putchar sink, a finish register and a small dword scratch RAM.
//   Ports: clk_i, reset_i (async, active-high); io_cmd_i/io_cmd_v_i/io_cmd_yumi_o
//   (command in); io_resp_o/io_resp_v_o/io_resp_ready_and_i (response out);
//   char_o/char_v_o (putchar), finish_o/finish_code_o (finish), error_o (sticky).
//   Optional feature macro: BP_IO_RESPONDER_PERF_EN (accepted-command counter at PERF).
module bp_fpga_host_io_responder
   import bp_fpga_host_pkg::*;
#(
   parameter bp_params_e bp_params_p   = e_bp_default_cfg,
   parameter int         scratch_els_p = 64
)
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  bp_bedrock_io_mem_msg_s io_cmd_i,
   input  logic                   io_cmd_v_i,
   output logic                   io_cmd_yumi_o,
   output bp_bedrock_io_mem_msg_s io_resp_o,
   output logic                   io_resp_v_o,
   input  logic                   io_resp_ready_and_i,
   output logic [7:0]             char_o,
   output logic                   char_v_o,
   output logic                   finish_o,
   output logic [7:0]             finish_code_o,
   output logic                   error_o
);

   localparam int lg_els_lp      = $clog2(scratch_els_p);
   localparam int paddr_width_lp = bp_paddr_width_f(bp_params_p);

   bp_io_resp_state_e         state_q, state_d;
   bp_bedrock_io_mem_header_s hdr_q, hdr_d;
   bp_io_target_e             tgt_q, tgt_d, tgt_in_s;
   bp_bedrock_io_mem_msg_s    resp_q, resp_d;
   logic [63:0]               misc_q, misc_d;
   logic                      resp_v_q, resp_v_d, char_v_q, char_v_d;
   logic                      finish_q, finish_d, error_q, error_d;
   logic [7:0]                char_q, char_d, code_q, code_d;
   logic [paddr_width_lp-1:0] cmd_addr_s;
   logic [63:0]               ram_rdata_s, ram_wdata_s;
   logic [7:0]                ram_mask_s;
   logic                      accept_s, is_wr_in_s, ram_v_s;
`ifdef BP_IO_RESPONDER_PERF_EN
   logic [31:0]               perf_q, perf_d;
`endif

   assign cmd_addr_s  = io_cmd_i.header.addr;
   assign tgt_in_s    = bp_io_decode_f(cmd_addr_s, io_cmd_i.header.size,
                                       io_cmd_i.header.msg_type, lg_els_lp);
   assign is_wr_in_s  = (io_cmd_i.header.msg_type == e_bedrock_mem_uc_wr);
   assign accept_s    = io_cmd_v_i && (state_q == e_ready) && !reset_i;
   // The RAM is accessed on the accept edge so read data is ready in e_access
   assign ram_v_s     = accept_s && (tgt_in_s == e_tgt_scratch);
   assign ram_wdata_s = io_cmd_i.data << {cmd_addr_s[2:0], 3'b000};
   assign ram_mask_s  = bp_io_byte_mask_f(io_cmd_i.header.size, cmd_addr_s[2:0]);

   bp_io_responder_scratch_ram #(.els_p(scratch_els_p)) scratch_ram (
      .clk_i  (clk_i),
      .v_i    (ram_v_s),
      .w_i    (is_wr_in_s),
      .addr_i (cmd_addr_s[3 +: lg_els_lp]),
      .data_i (ram_wdata_s),
      .mask_i (ram_mask_s),
      .data_o (ram_rdata_s)
   );

   // Next-state: side effects on accept, response build in e_access, handshake in e_resp
   always_comb begin
      state_d  = state_q;
      hdr_d    = hdr_q;
      tgt_d    = tgt_q;
      misc_d   = misc_q;
      resp_d   = resp_q;
      resp_v_d = resp_v_q;
      char_d   = char_q;
      char_v_d = 1'b0;
      finish_d = finish_q;
      code_d   = code_q;
      error_d  = error_q;
`ifdef BP_IO_RESPONDER_PERF_EN
      perf_d   = accept_s ? (perf_q + 32'd1) : perf_q;
`endif
      case (state_q)
         e_ready: begin
            if (accept_s) begin
               state_d = e_access;
               hdr_d   = io_cmd_i.header;
               tgt_d   = tgt_in_s;
               misc_d  = 64'd0;
               error_d = error_q | (tgt_in_s == e_tgt_none);
               case (tgt_in_s)
                  e_tgt_putchar: begin
                     if (is_wr_in_s) begin
                        char_d   = io_cmd_i.data[7:0];
                        char_v_d = 1'b1;
                     end else begin
                        char_d   = char_q;
                     end
                  end
                  e_tgt_finish: begin
                     if (is_wr_in_s) begin
                        finish_d = 1'b1;
                        code_d   = io_cmd_i.data[7:0];
                     end else begin
                        misc_d   = {55'd0, code_q, finish_q};
                     end
                  end
`ifdef BP_IO_RESPONDER_PERF_EN
                  e_tgt_perf: begin
                     // Reads see the pre-increment count; the clearing write is not counted
                     if (is_wr_in_s) begin
                        perf_d = 32'd0;
                     end else begin
                        misc_d = {32'd0, perf_q};
                     end
                  end
`endif
                  default: misc_d = 64'd0;
               endcase
            end else begin
               state_d = e_ready;
            end
         end
         e_access: begin
            state_d          = e_resp;
            resp_v_d         = 1'b1;
            resp_d.header    = hdr_q;
            if (hdr_q.msg_type == e_bedrock_mem_uc_rd) begin
               resp_d.data = (tgt_q == e_tgt_scratch) ? ram_rdata_s : misc_q;
            end else begin
               resp_d.data = 64'd0;
            end
         end
         e_resp: begin
            if (io_resp_ready_and_i) begin
               resp_v_d = 1'b0;
               state_d  = e_ready;
            end else begin
               resp_v_d = 1'b1;
            end
         end
         default: state_d = e_ready;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= e_ready;
         hdr_q    <= '0;
         tgt_q    <= e_tgt_none;
         misc_q   <= 64'd0;
         resp_q   <= '0;
         resp_v_q <= 1'b0;
         char_q   <= 8'd0;
         char_v_q <= 1'b0;
         finish_q <= 1'b0;
         code_q   <= 8'd0;
         error_q  <= 1'b0;
`ifdef BP_IO_RESPONDER_PERF_EN
         perf_q   <= 32'd0;
`endif
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         tgt_q    <= tgt_d;
         misc_q   <= misc_d;
         resp_q   <= resp_d;
         resp_v_q <= resp_v_d;
         char_q   <= char_d;
         char_v_q <= char_v_d;
         finish_q <= finish_d;
         code_q   <= code_d;
         error_q  <= error_d;
`ifdef BP_IO_RESPONDER_PERF_EN
         perf_q   <= perf_d;
`endif
      end
   end

   assign io_cmd_yumi_o = accept_s;
   assign io_resp_o     = resp_q;
   assign io_resp_v_o   = resp_v_q;
   assign char_o        = char_q;
   assign char_v_o      = char_v_q;
   assign finish_o      = finish_q;
   assign finish_code_o = code_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_bp_fpga_host_io_responder.sv
module tb_bp_fpga_host_io_responder;
   import bp_fpga_host_pkg::*;

   localparam int els_lp = 64;
   localparam logic [39:0] putchar_a = 40'h00_0010_1000;
   localparam logic [39:0] finish_a  = 40'h00_0010_2000;
   localparam logic [39:0] scratch_a = 40'h00_0010_3000;
   localparam logic [39:0] perf_a    = 40'h00_0010_4000;

   logic clk = 1'b0, rst = 1'b1;
   bp_bedrock_io_mem_msg_s cmd, resp;
   logic cmd_v, yumi, resp_v, ready, char_v, fin, err;
   logic [7:0] chr, code;

   bp_fpga_host_io_responder #(.scratch_els_p(els_lp)) dut (
      .clk_i(clk), .reset_i(rst),
      .io_cmd_i(cmd), .io_cmd_v_i(cmd_v), .io_cmd_yumi_o(yumi),
      .io_resp_o(resp), .io_resp_v_o(resp_v), .io_resp_ready_and_i(ready),
      .char_o(chr), .char_v_o(char_v), .finish_o(fin), .finish_code_o(code), .error_o(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   // reference model state
   logic [7:0]  m_mem   [els_lp*8];
   bit          m_known [els_lp*8];
   logic [7:0]  m_char = 8'd0, m_code = 8'd0;
   bit          m_finish = 1'b0, m_error = 1'b0;
   logic [31:0] m_perf = 32'd0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_char = 8'd0; m_code = 8'd0; m_finish = 1'b0; m_error = 1'b0; m_perf = 32'd0;
   endtask

   // Behavioural device-window model: byte-addressed scratch, plain registers
   task automatic model_cmd(input bp_bedrock_mem_type_e t, input logic [2:0] sz,
                            input logic [39:0] addr, input logic [63:0] data,
                            output logic [63:0] exp_rd, output bit exp_cv, output bit known);
      longint unsigned nb, off;
      bit ok, is_rd, no_count;
      exp_rd = 64'd0; exp_cv = 1'b0; known = 1'b1; no_count = 1'b0;
      is_rd = (t == e_bedrock_mem_uc_rd);
      ok = (is_rd || t == e_bedrock_mem_uc_wr) && (sz <= 3'd3);
      nb = longint'(1) << sz;
      if (ok && (addr % nb) != 0) ok = 1'b0;
      if (!ok) m_error = 1'b1;
      else if (addr == putchar_a) begin
         if (!is_rd) begin m_char = data[7:0]; exp_cv = 1'b1; end
      end else if (addr == finish_a) begin
         if (is_rd) exp_rd = 64'(m_code) * 64'd2 + 64'(m_finish);
         else begin m_finish = 1'b1; m_code = data[7:0]; end
      end
`ifdef BP_IO_RESPONDER_PERF_EN
      else if (addr == perf_a) begin
         if (is_rd) exp_rd = 64'(m_perf);
         else begin m_perf = 32'd0; no_count = 1'b1; end
      end
`endif
      else if (addr >= scratch_a && addr < scratch_a + 40'(8*els_lp)) begin
         off = addr - scratch_a;
         if (is_rd) begin
            for (int j = 0; j < 8; j++) begin
               if (!m_known[(off & ~longint'(7)) + j]) known = 1'b0;
               exp_rd[8*j +: 8] = m_mem[(off & ~longint'(7)) + j];
            end
         end else begin
            for (int j = 0; j < int'(nb); j++) begin
               m_mem[off + j] = data[8*j +: 8];
               m_known[off + j] = 1'b1;
            end
         end
      end else m_error = 1'b1;
      if (!no_count) m_perf = m_perf + 32'd1;
   endtask

   task automatic drive_cmd(input bp_bedrock_mem_type_e t, input logic [2:0] sz,
                            input logic [39:0] addr, input logic [63:0] data);
      cmd.header.msg_type = t;
      cmd.header.size     = bp_bedrock_msg_size_e'(sz);
      cmd.header.addr     = addr;
      cmd.data            = data;
      cmd_v               = 1'b1;
   endtask

   // One full transaction with ready held high; checks N+1 and N+2 behaviour
   task automatic run_cmd(input bp_bedrock_mem_type_e t, input logic [2:0] sz,
                          input logic [39:0] addr, input logic [63:0] data,
                          input string tag, output logic [63:0] got);
      logic [63:0] exp_rd;
      bit exp_cv, known;
      int k;
      bp_bedrock_io_mem_header_s exp_hdr;
      exp_hdr.msg_type = t;
      exp_hdr.size     = bp_bedrock_msg_size_e'(sz);
      exp_hdr.addr     = addr;
      @(negedge clk);
      drive_cmd(t, sz, addr, data);
      #1;
      k = 0;
      while (!yumi && k < 8) begin @(negedge clk); #1; k++; end
      check_eq({tag, "_yumi"}, 64'(yumi), 64'd1);
      model_cmd(t, sz, addr, data, exp_rd, exp_cv, known);
      @(posedge clk); #1; cmd_v = 1'b0;
      @(negedge clk); #1;
      check_eq({tag, "_charv_n1"}, 64'(char_v), 64'(exp_cv));
      check_eq({tag, "_char"}, 64'(chr), 64'(m_char));
      check_eq({tag, "_respv_n1"}, 64'(resp_v), 64'd0);
      check_eq({tag, "_error"}, 64'(err), 64'(m_error));
      check_eq({tag, "_finish"}, {55'd0, code, fin}, 64'(m_code) * 64'd2 + 64'(m_finish));
      @(negedge clk); #1;
      check_eq({tag, "_respv_n2"}, 64'(resp_v), 64'd1);
      check_eq({tag, "_hdr"}, 64'(resp.header), 64'(exp_hdr));
      if (known) check_eq({tag, "_data"}, resp.data, exp_rd);
      check_eq({tag, "_charv_n2"}, 64'(char_v), 64'd0);
      got = resp.data;
      @(posedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_respv"}, 64'(resp_v), 64'd0);
      check_eq({tag, "_resp"}, {17'd0, resp.header}, 64'd0);
      check_eq({tag, "_respd"}, resp.data, 64'd0);
      check_eq({tag, "_outs"}, {46'd0, chr, char_v, fin, code, err}, 64'd0);
   endtask

   logic [63:0] got;
   logic [63:0] exp_a, exp_b;
   bit cv, kn;

   initial begin
      cmd = '0; cmd_v = 1'b0; ready = 1'b1;
      for (int i = 0; i < els_lp*8; i++) begin m_known[i] = 1'b0; m_mem[i] = 8'd0; end

      // reset state, including yumi suppressed while reset is high
      repeat (2) @(negedge clk);
      cmd_v = 1'b1; #1;
      check_eq("rst_yumi", 64'(yumi), 64'd0);
      check_all_zero("rst");
      cmd_v = 1'b0;
      @(negedge clk); rst = 1'b0;

      // putchar
      run_cmd(e_bedrock_mem_uc_wr, 3'd0, putchar_a, 64'h41, "putchar", got);
      check_eq("putchar_char", 64'(chr), 64'h41);
      check_eq("putchar_respdata", got, 64'd0);

      // scratch byte merge
      run_cmd(e_bedrock_mem_uc_wr, 3'd3, scratch_a + 40'h8, 64'h1122_3344_5566_7788, "sc_wr8", got);
      run_cmd(e_bedrock_mem_uc_wr, 3'd1, scratch_a + 40'hA, 64'hBEEF, "sc_wr2", got);
      run_cmd(e_bedrock_mem_uc_rd, 3'd3, scratch_a + 40'h8, 64'd0, "sc_rd", got);
      check_eq("scratch_merge", got, 64'h1122_3344_BEEF_7788);

      // finish, then async reset in e_access of the next command
      run_cmd(e_bedrock_mem_uc_wr, 3'd0, finish_a, 64'h5A, "finish", got);
      check_eq("finish_flag", {55'd0, code, fin}, 64'h0B5);
      @(negedge clk);
      drive_cmd(e_bedrock_mem_uc_rd, 3'd3, scratch_a + 40'h8, 64'd0);
      #1 check_eq("rstmid_yumi", 64'(yumi), 64'd1);
      @(posedge clk); #2; cmd_v = 1'b0; rst = 1'b1; #1;
      check_all_zero("rstmid");
      @(negedge clk); @(negedge clk); rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1 check_eq("rstmid_noresp", 64'(resp_v), 64'd0);
      end

      // perf counter (or unmapped PERF)
      check_eq("perf_pre_err", 64'(err), 64'd0);
`ifdef BP_IO_RESPONDER_PERF_EN
      run_cmd(e_bedrock_mem_uc_wr, 3'd3, perf_a, 64'd0, "perf_clr", got);
      run_cmd(e_bedrock_mem_uc_rd, 3'd0, putchar_a, 64'd0, "perf_c1", got);
      run_cmd(e_bedrock_mem_uc_rd, 3'd3, finish_a, 64'd0, "perf_c2", got);
      run_cmd(e_bedrock_mem_uc_wr, 3'd0, putchar_a, 64'h43, "perf_c3", got);
      run_cmd(e_bedrock_mem_uc_rd, 3'd3, perf_a, 64'd0, "perf_rd", got);
      check_eq("perf_count", got, 64'd3);
`else
      run_cmd(e_bedrock_mem_uc_rd, 3'd3, perf_a, 64'd0, "perf_rd", got);
      check_eq("perf_unmapped_err", 64'(err), 64'd1);
      check_eq("perf_unmapped_data", got, 64'd0);
`endif

      // unmapped and misaligned errors
      run_cmd(e_bedrock_mem_uc_rd, 3'd3, 40'h00_0020_0000, 64'd0, "unmapped", got);
      check_eq("unmapped_data", got, 64'd0);
      check_eq("unmapped_err", 64'(err), 64'd1);
      run_cmd(e_bedrock_mem_uc_wr, 3'd3, scratch_a, 64'hCAFE_F00D_0123_4567, "sc0_wr", got);
      run_cmd(e_bedrock_mem_uc_wr, 3'd2, scratch_a + 40'h3, 64'hFFFF_FFFF, "misal_wr", got);
      run_cmd(e_bedrock_mem_uc_rd, 3'd3, scratch_a, 64'd0, "sc0_rd", got);
      check_eq("misal_ram_unchanged", got, 64'hCAFE_F00D_0123_4567);
      check_eq("err_sticky", 64'(err), 64'd1);

      // backpressure: response held 5 cycles while a second command waits
      @(negedge clk);
      model_cmd(e_bedrock_mem_uc_rd, 3'd3, scratch_a + 40'h8, 64'd0, exp_a, cv, kn);
      drive_cmd(e_bedrock_mem_uc_rd, 3'd3, scratch_a + 40'h8, 64'd0);
      ready = 1'b0;
      #1 check_eq("bp_yumi_a", 64'(yumi), 64'd1);
      @(posedge clk);
      @(negedge clk);
      drive_cmd(e_bedrock_mem_uc_rd, 3'd0, putchar_a, 64'd0);
      #1 check_eq("bp_yumi_n1", 64'(yumi), 64'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         check_eq("bp_respv", 64'(resp_v), 64'd1);
         check_eq("bp_data", resp.data, 64'h1122_3344_BEEF_7788);
         check_eq("bp_yumi_hold", 64'(yumi), 64'd0);
         @(negedge clk);
      end
      ready = 1'b1;
      #1 check_eq("bp_yumi_onready", 64'(yumi), 64'd0);
      @(posedge clk);
      @(negedge clk); #1;
      check_eq("bp_yumi_next", 64'(yumi), 64'd1);
      model_cmd(e_bedrock_mem_uc_rd, 3'd0, putchar_a, 64'd0, exp_b, cv, kn);
      @(posedge clk); #1; cmd_v = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      check_eq("bp_b_respv", 64'(resp_v), 64'd1);
      check_eq("bp_b_data", resp.data, exp_b);
      @(posedge clk);

      // randomized traffic against the model; start by defining every scratch dword
      for (int i = 0; i < els_lp; i++)
         run_cmd(e_bedrock_mem_uc_wr, 3'd3, scratch_a + 40'(8*i),
                 {$urandom, $urandom}, "init", got);
      for (int n = 0; n < 300; n++) begin
         bp_bedrock_mem_type_e t;
         logic [2:0] sz;
         logic [39:0] a;
         int r, k;
         k = $urandom_range(0, 9);
         t = (k == 0) ? e_bedrock_mem_rd : ((k < 5) ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr);
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         case (r)
            0: a = putchar_a;
            1: a = finish_a;
            2: a = perf_a;
            3: a = ($urandom_range(0, 1) == 0) ? scratch_a + 40'(8*els_lp) + 40'($urandom_range(0, 7))
                                               : 40'h00_0020_0000 + 40'($urandom_range(0, 65535));
            default: a = scratch_a + 40'(8*$urandom_range(0, els_lp-1)) + 40'($urandom_range(0, 7));
         endcase
         run_cmd(t, sz, a, {$urandom, $urandom}, "rand", got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
